// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit enable register among four requesters.
// Optional feature macro: SHARED_REG_LOCK_EN enables the LOCKED state (exclusive ownership).
module shared_reg_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data,
    input  logic [3:0]         lock,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   q,
    output logic [1:0]         last_id,
    output logic [15:0]        wr_count,
    output logic               locked
);
    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 16;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

`ifdef SHARED_REG_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_win;
    logic [3:0]       w_lock;
    logic [3:0]       w_gnt;
    logic             w_wr;
    logic             w_release;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_reg_d;
    logic             w_reg_en;
    logic [1:0]       r_last_id;
    logic [CNT_W-1:0] r_wr_count;
    logic             r_locked;

    // With the lock feature compiled out the lock lanes read as all-zero.
    assign w_lock = lock & {NREQ{LOCK_EN}};

    // Winner selection, grant generation and next state.
    always_comb begin
        w_win       = r_ptr;
        w_gnt       = '0;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_release   = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_win          = r_owner;
            w_gnt[r_owner] = req[r_owner];
            if (!w_lock[r_owner]) begin
                w_state_nxt = ST_ARB;
                w_release   = 1'b1;
            end
        end else begin
            // Scan from the far end so the index closest to ptr is assigned last.
            for (int k = 3; k >= 0; k--) begin
                if (req[r_ptr + 2'(k)]) begin
                    w_win = r_ptr + 2'(k);
                end
            end
            w_gnt[w_win] = req[w_win];
            if (req[w_win] && w_lock[w_win]) begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_win;
            end
        end
        if (reset) begin
            w_gnt = '0;
        end
    end

    assign w_wr     = |w_gnt;
    assign w_reg_en = w_wr;
    assign w_reg_d  = data[w_win*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ARB;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Shared enable register fed by the winning lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (w_reg_en) begin
            r_q <= w_reg_d;
        end
    end

    // In LOCKED the winner is the owner, so a release also lands ptr at owner+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_last_id  <= '0;
            r_wr_count <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_locked <= (w_state_nxt == ST_LOCKED);
            if (w_wr) begin
                r_last_id  <= w_win;
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
            if (w_wr || w_release) begin
                r_ptr <= w_win + 2'd1;
            end
        end
    end

    assign gnt      = w_gnt;
    assign q        = r_q;
    assign last_id  = r_last_id;
    assign wr_count = r_wr_count;
    assign locked   = r_locked;

endmodule
